control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Hardwired Moore control sequencer for the 32-bit RISC datapath (DataPath).
//  Fetches each instruction, decodes IR[31:27] and drives every datapath strobe, step by step (T0..T7).
//  It replaces the hand-sequenced strobes of the per-instruction benches.
//  It sits beside DataPath in the CPU top level; the IR value, CON FF result and stop request are its only inputs.
// PARAMETERS
//  OPW     5   opcode width, IR[31:27]
//  IRW     32  instruction register width
// PORTS
//  clock      in   1    system clock; all state changes on posedge
//  clear      in   1    synchronous, active-low reset
//  ir         in   IRW  current IR contents
//  con_ff     in   1    branch condition result from CON FF
//  stop       in   1    external halt request
//  run        out  1    1 while executing, 0 in reset/HALT
//  illegal    out  1    1-cycle pulse on an undefined opcode
//  opcode     out  OPW  ALU operation select
//  PCout,PCin,IncPC                   out 1 ea  PC strobes
//  MARin,MDRin,MDRout,Read,Write      out 1 ea  memory strobes
//  IRin,Yin,ZHighIn,ZLowIn,Zhighout,Zlowout  out 1 ea  internal register strobes
//  Gra,Grb,Grc,Rin,Rout,BAout,Cout    out 1 ea  select/encode strobes
//  HIin,LOin,HIout,LOout,CONin,InPortout,OutPortin  out 1 ea  special register strobes
// BEHAVIOUR
//  - Moore FSM: outputs decode from the state register only. Each state lasts exactly one clock.
//  - Reset: the first posedge that samples clear=0 moves the FSM to RST. In RST, every strobe, opcode, illegal and run are 0.
//    This also applies mid-instruction: there is no partial completion.
//  - The first posedge with clear=1 moves RST to T0. run=1 from T0 onward.
//  - Memory is single-cycle: data is valid on MDR input in the same state that Read is asserted.
//  - Fetch (all instructions):
//    - T0: PCout MARin IncPC ZLowIn
//    - T1: Zlowout PCin Read MDRin
//    - T2: MDRout IRin
//  - Execute steps. ADD means opcode=ADD code. Unlisted strobes are 0:
//    - ALU R-type (add,sub,and,or,ror,rol,shr,shra,shl):
//      T3 Grb Rout Yin; T4 Grc Rout opcode=IR op ZLowIn; T5 Zlowout Gra Rin.
//    - ALU imm (addi,andi,ori): as R-type, but T4 uses Cout in place of Grc Rout.
//    - mul/div: T3 Gra Rout Yin; T4 Grb Rout opcode ZHighIn ZLowIn; T5 Zlowout LOin; T6 Zhighout HIin.
//    - neg/not: T3 Grb Rout opcode ZLowIn; T4 Zlowout Gra Rin.
//    - ld:  T3 Grb BAout Yin; T4 Cout ADD ZLowIn; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
//    - ldi: T3 Grb BAout Yin; T4 Cout ADD ZLowIn; T5 Zlowout Gra Rin.
//    - st:  T3-T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
//    - br:  T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD ZLowIn; T6 Zlowout, plus PCin only if con_ff=1.
//    - jr:  T3 Gra Rout PCin.
//    - jal: T3 PCout Grb Rin; T4 Gra Rout PCin.
//    - in/out: T3 InPortout Gra Rin / Gra Rout OutPortin.
//    - mfhi/mflo: T3 HIout / LOout, Gra Rin.
//    - nop: no execute step; T2 returns to T0.
//    - halt: T2 goes to HALT.
//  - After the last execute step, the FSM goes to T0. If stop=1 is sampled on that edge, it goes to HALT instead.
//  - HALT: all strobes 0, run=0. The FSM stays in HALT until clear=0.
//  - An undefined opcode acts as nop and pulses illegal during the T2->T0 transition cycle.
//  - The opcode output is 0 in every state not listed above.
//  - Read and Write are never both 1. PCin and IncPC are never both 1.
// STRUCTURE
//  - Package cpu_ctrl_pkg holds:
//    - state enum: RST, T0-T7, HALT
//    - opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110,
//      ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110,
//      div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110,
//      out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011
//    - instruction-class enum
//  - Sub-module ir_class_decode (combinational): maps ir[31:27] to instruction class plus a last-step index.
//    The FSM uses the last-step index to know when the instruction is done.
// TESTING
//  1. clear=0 for 2 cycles, then 1 -> all strobes 0 and run=0 in RST; T0 strobes appear on the next cycle with run=1.
//  2. ir=0x19890000 (add R3,R1,R2) -> T3 Grb Rout Yin; T4 Grc Rout opcode=00011; T5 Zlowout Gra Rin; 6 cycles, then T0.
//  3. jal (opcode 10101) -> T3 PCout Grb Rin; T4 Gra Rout PCin; 5 cycles total; IncPC never coincides with PCin.
//  4. br with con_ff=0 -> T6 shows Zlowout with PCin=0. Same instruction with con_ff=1 -> PCin=1 in T6.
//  5. st -> T6 MDRin=1 with Read=0; T7 Write=1. Assert clear=0 during T5 of an ld -> all strobes 0 on the next cycle, then T0.
//  6. halt opcode, or stop=1 at the end of an instruction -> HALT with run=0 and all strobes 0 for 10 cycles; exit only via clear.
//     Opcode 11111 -> illegal pulse for 1 cycle, then fetch resumes.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the hardwired RISC control sequencer: state encoding,
// opcode map, instruction classes and the bundle of datapath strobes.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 5;

  // T0..T7 occupy codes 0..7 so the low three bits give the step number.
  typedef enum logic [3:0] {
    ST_RST  = 4'd8,
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd9
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OPCODE_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPCODE_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPCODE_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [4:0] {
    CL_ALU_R, CL_ALU_I, CL_MULDIV, CL_NEGNOT, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
  } iclass_e;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, read, write;
    logic ir_in, y_in, zhigh_in, zlow_in, zhigh_out, zlow_out;
    logic gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic hi_in, lo_in, hi_out, lo_out, con_in, in_port_out, out_port_in;
  } strobes_t;

  function automatic logic [2:0] step_idx(input state_e s);
    return s[2:0];
  endfunction

endpackage

// File: rtl/ir_class_decode.sv
// Maps the IR opcode field to an instruction class and the index of the
// final execute step (T2 for instructions with no execute phase).
module ir_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] op,
  output iclass_e             iclass,
  output logic [2:0]          last_step
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    iclass = CL_ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:   iclass = CL_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:          iclass = CL_ALU_I;
      OP_MUL, OP_DIV:                    iclass = CL_MULDIV;
      OP_NEG, OP_NOT:                    iclass = CL_NEGNOT;
      OP_LD:                             iclass = CL_LD;
      OP_LDI:                            iclass = CL_LDI;
      OP_ST:                             iclass = CL_ST;
      OP_BR:                             iclass = CL_BR;
      OP_JR:                             iclass = CL_JR;
      OP_JAL:                            iclass = CL_JAL;
      OP_IN:                             iclass = CL_IN;
      OP_OUT:                            iclass = CL_OUT;
      OP_MFHI:                           iclass = CL_MFHI;
      OP_MFLO:                           iclass = CL_MFLO;
      OP_NOP:                            iclass = CL_NOP;
      OP_HALT:                           iclass = CL_HALT;
      default:                           iclass = CL_ILLEGAL;
    endcase
  end

  always_comb begin
    last_step = 3'd2;
    case (iclass)
      CL_ALU_R, CL_ALU_I, CL_LDI:              last_step = 3'd5;
      CL_MULDIV, CL_BR:                        last_step = 3'd6;
      CL_NEGNOT, CL_JAL:                       last_step = 3'd4;
      CL_LD, CL_ST:                            last_step = 3'd7;
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO:  last_step = 3'd3;
      default:                                 last_step = 3'd2;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetches via T0..T2, then steps through the
// execute states of the decoded instruction class, driving all datapath strobes.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = OPCODE_W,
  parameter int IRW = 32
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [IRW-1:0] ir,
  input  logic           con_ff,
  input  logic           stop,
  output logic           run,
  output logic           illegal,
  output logic [OPW-1:0] opcode,
  output logic PCout, PCin, IncPC,
  output logic MARin, MDRin, MDRout, Read, Write,
  output logic IRin, Yin, ZHighIn, ZLowIn, Zhighout, Zlowout,
  output logic Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic HIin, LOin, HIout, LOout, CONin, InPortout, OutPortin
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [2:0] last_step;
  logic [OPW-1:0] op;
  strobes_t   strb;
  logic       unused_ir_bits;

  assign op             = ir[IRW-1 -: OPW];
  assign unused_ir_bits = ^ir[IRW-OPW-1:0];

  ir_class_decode u_decode (
    .op        (op),
    .iclass    (iclass),
    .last_step (last_step)
  );

  always_ff @(posedge clock) begin
    // NOTE: non-blocking so the register samples values from before the edge.
    if (!clear) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (state_q == ST_T2 && iclass == CL_HALT)  state_d = ST_HALT;
        else if (step_idx(state_q) == last_step)    state_d = stop ? ST_HALT : ST_T0;
        else                                        state_d = state_e'(state_q + 4'd1);
      end
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    strb    = '0;
    opcode  = '0;
    illegal = 1'b0;
    case (state_q)
      ST_T0: begin strb.pc_out = 1'b1; strb.mar_in = 1'b1; strb.inc_pc = 1'b1; strb.zlow_in = 1'b1; end
      ST_T1: begin strb.zlow_out = 1'b1; strb.pc_in = 1'b1; strb.read = 1'b1; strb.mdr_in = 1'b1; end
      ST_T2: begin
        strb.mdr_out = 1'b1;
        strb.ir_in   = 1'b1;
        illegal      = (iclass == CL_ILLEGAL);
      end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        case (iclass)
          CL_ALU_R, CL_ALU_I: case (state_q)
            ST_T3: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
            ST_T4: begin
              strb.zlow_in = 1'b1;
              opcode       = op;
              if (iclass == CL_ALU_I) strb.c_out = 1'b1;
              else begin strb.grc = 1'b1; strb.r_out = 1'b1; end
            end
            ST_T5:   begin strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
            default: ;
          endcase
          CL_MULDIV: case (state_q)
            ST_T3: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
            ST_T4: begin
              strb.grb = 1'b1; strb.r_out = 1'b1; strb.zhigh_in = 1'b1; strb.zlow_in = 1'b1;
              opcode   = op;
            end
            ST_T5:   begin strb.zlow_out = 1'b1; strb.lo_in = 1'b1; end
            ST_T6:   begin strb.zhigh_out = 1'b1; strb.hi_in = 1'b1; end
            default: ;
          endcase
          CL_NEGNOT: case (state_q)
            ST_T3:   begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.zlow_in = 1'b1; opcode = op; end
            ST_T4:   begin strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
            default: ;
          endcase
          // Effective address is Rb (or 0 via BAout) plus the constant field.
          CL_LD, CL_LDI, CL_ST: case (state_q)
            ST_T3: begin strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_in = 1'b1; end
            ST_T4: begin strb.c_out = 1'b1; strb.zlow_in = 1'b1; opcode = OP_ADD; end
            ST_T5: begin
              strb.zlow_out = 1'b1;
              if (iclass == CL_LDI) begin strb.gra = 1'b1; strb.r_in = 1'b1; end
              else                  strb.mar_in = 1'b1;
            end
            ST_T6: begin
              strb.mdr_in = 1'b1;
              if (iclass == CL_ST) begin strb.gra = 1'b1; strb.r_out = 1'b1; end
              else                 strb.read = 1'b1;
            end
            ST_T7: begin
              if (iclass == CL_ST) strb.write = 1'b1;
              else begin strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
            end
            default: ;
          endcase
          CL_BR: case (state_q)
            ST_T3:   begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.con_in = 1'b1; end
            ST_T4:   begin strb.pc_out = 1'b1; strb.y_in = 1'b1; end
            ST_T5:   begin strb.c_out = 1'b1; strb.zlow_in = 1'b1; opcode = OP_ADD; end
            ST_T6:   begin strb.zlow_out = 1'b1; strb.pc_in = con_ff; end
            default: ;
          endcase
          CL_JR:  if (state_q == ST_T3) begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; end
          CL_JAL: case (state_q)
            ST_T3:   begin strb.pc_out = 1'b1; strb.grb = 1'b1; strb.r_in = 1'b1; end
            ST_T4:   begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; end
            default: ;
          endcase
          CL_IN:   if (state_q == ST_T3) begin strb.in_port_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
          CL_OUT:  if (state_q == ST_T3) begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.out_port_in = 1'b1; end
          CL_MFHI: if (state_q == ST_T3) begin strb.hi_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
          CL_MFLO: if (state_q == ST_T3) begin strb.lo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign run = (state_q != ST_RST) && (state_q != ST_HALT);

  assign PCout     = strb.pc_out;
  assign PCin      = strb.pc_in;
  assign IncPC     = strb.inc_pc;
  assign MARin     = strb.mar_in;
  assign MDRin     = strb.mdr_in;
  assign MDRout    = strb.mdr_out;
  assign Read      = strb.read;
  assign Write     = strb.write;
  assign IRin      = strb.ir_in;
  assign Yin       = strb.y_in;
  assign ZHighIn   = strb.zhigh_in;
  assign ZLowIn    = strb.zlow_in;
  assign Zhighout  = strb.zhigh_out;
  assign Zlowout   = strb.zlow_out;
  assign Gra       = strb.gra;
  assign Grb       = strb.grb;
  assign Grc       = strb.grc;
  assign Rin       = strb.r_in;
  assign Rout      = strb.r_out;
  assign BAout     = strb.ba_out;
  assign Cout      = strb.c_out;
  assign HIin      = strb.hi_in;
  assign LOin      = strb.lo_in;
  assign HIout     = strb.hi_out;
  assign LOout     = strb.lo_out;
  assign CONin     = strb.con_in;
  assign InPortout = strb.in_port_out;
  assign OutPortin = strb.out_port_in;

endmodule
